issue_queue: RTL and testbench
==============================

ISSUE_QUEUE -- requirements
Module: issue_queue

Interface
REQ-001 Parameter DEPTH, default 8, queue entries; SHALL be a power of two, at least 4.
REQ-002 Parameter W, default 32, instruction and PC width.
REQ-003 clk  input  1  sole clock; all state changes on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  fetch pair present on in_ins0/in_ins1.
REQ-006 in_ins0, in_ins1  input  W  fetched pair, in_ins0 older.
REQ-007 in_pc  input  W  word address of in_ins0; in_ins1 is in_pc+1.
REQ-008 flush  input  1  redirect (taken jr/jal/beq); discard all queued entries.
REQ-009 issue_en  input  1  back-end accepts issue this cycle.
REQ-010 full  output  1  fewer than 2 free entries; the PC stage holds its address.
REQ-011 out_valid0  output  1  out_ins0 valid for ALU1.
REQ-012 out_dual  output  1  out_ins1 valid for ALU2 (alu2_en).
REQ-013 out_ins0, out_ins1  output  W  issued instructions; 0 (NOP) when not valid.
REQ-014 out_pc0  output  W  word address of out_ins0; out_ins1 is out_pc0+1.
REQ-015 count  output  clog2(DEPTH)+1  occupied entries.

Function
REQ-016 Storage: circular buffer of DEPTH entries {ins, pc}; head/tail wrap modulo DEPTH; full and empty are distinguished by count, never by pointer equality.
REQ-017 Enqueue: on an edge with in_valid=1, flush=0, full=0, write both instructions at tail and tail+1; count +2.
REQ-018 in_valid while full=1 SHALL NOT write or drop state; the upstream stage repeats the pair.
REQ-019 full SHALL be combinational from count: full = (DEPTH - count < 2).
REQ-020 Issue: on an edge with issue_en=1, flush=0: count>=1 -> out_valid0=1, out_ins0/out_pc0 = head entry, head +1.
REQ-021 Dual: also issue head+1 (out_dual=1, head +2) only if count>=2 and all of: head not control; head+1 not control; head+1 not lw (100011) or sw (101011); no RAW or WAW hazard.
REQ-022 Control: opcode 000000 with funct 001000 (jr), opcode 000011 (jal), opcode 000100 (beq).
REQ-023 Destination of head: R-type -> [15:11]; addi (001000) or lw -> [20:16]; jal -> 31; otherwise none; dest 0 counts as none.
REQ-024 RAW: head dest equals [25:21] or [20:16] of head+1. WAW: head dest equals head+1 dest.
REQ-025 Instructions never issue out of order; head+1 never issues without head.
REQ-026 Latency: an entry enqueued at edge N is issuable no earlier than edge N+1 (no bypass from in_* to out_*).
REQ-027 Simultaneous enqueue and issue in one edge: both occur; count = count + 2 - issued; full uses pre-edge count.
REQ-028 issue_en=0 or count=0: outputs on that edge become out_valid0=0, out_dual=0, out_ins*=0; out_pc0 holds; queue unchanged except enqueue.
REQ-029 flush=1 at an edge: head=tail, count=0, out_valid0=0, out_dual=0, out_ins*=0; in_valid and issue_en on that edge are ignored.
REQ-030 Outputs out_* are registered; only full and count are combinational from state.

Reset
REQ-031 rst=0 SHALL immediately, independent of clk, force head=0, tail=0, count=0, out_valid0=0, out_dual=0, out_ins0=0, out_ins1=0, out_pc0=0; full=0.
REQ-032 Reset asserted mid-operation discards all entries; queue contents are don't-care after reset.
REQ-033 First enqueue is accepted on the first posedge after rst returns to 1.

Verification
REQ-034 Independent pair: enqueue add $3=$1+$2 / add $6=$4+$5 at pc 0x10, issue_en=1 -> next edge out_valid0=1, out_dual=1, out_pc0=0x10, count 2->0.
REQ-035 RAW: enqueue addi $8=$0+1 / add $9=$8+$8 -> first edge single issue (out_dual=0, out_ins1=0), next edge add issues alone with out_pc0=pc+1.
REQ-036 Fill: issue_en=0, in_valid=1 for 4 edges with DEPTH=8 -> count 8, full=1; fifth pair ignored, count stays 8; issue_en=1 restores full=0 after count<=6.
REQ-037 Wrap: stream 20 independent pairs with issue_en=1 every cycle, DEPTH=4 -> all 40 instructions issued in order, pcs consecutive, no loss or duplication.
REQ-038 Control/memory: pair jal / add -> jal issues alone; pair add / lw -> add issues alone; flush asserted with count=5 -> next edge count=0, outputs NOP.
REQ-039 Async reset: drive rst=0 between edges with count=6 -> count=0, outputs 0 before the next posedge.

Source files
------------

// File: rtl/issue_queue_if.sv
// Handshake bundle for the dual-issue instruction queue: the fetch side,
// the issue side with its flow control, and the occupancy outputs.
interface issue_queue_if #(
  parameter int DEPTH = 8,
  parameter int W     = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic [W-1:0]  in_ins0;
  logic [W-1:0]  in_ins1;
  logic [W-1:0]  in_pc;
  logic          flush;
  logic          issue_en;
  logic          full;
  logic          out_valid0;
  logic          out_dual;
  logic [W-1:0]  out_ins0;
  logic [W-1:0]  out_ins1;
  logic [W-1:0]  out_pc0;
  logic [CW-1:0] count;

  // Front/back-end side: drives fetch pairs and control, observes issue.
  modport master (
    output in_valid, in_ins0, in_ins1, in_pc, flush, issue_en,
    input  full, out_valid0, out_dual, out_ins0, out_ins1, out_pc0, count
  );

  // Queue side.
  modport slave (
    input  in_valid, in_ins0, in_ins1, in_pc, flush, issue_en,
    output full, out_valid0, out_dual, out_ins0, out_ins1, out_pc0, count
  );
endinterface

// File: rtl/issue_queue.sv
// Dual-issue instruction queue: accepts fetched instruction pairs into a
// circular buffer and issues one or two in-order instructions per cycle,
// pairing only when the second is independent of the first.
module issue_queue #(
  parameter int DEPTH = 8,
  parameter int W     = 32
) (
  input logic        clk,
  input logic        rst,
  issue_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_TWO = CW'(2);
  localparam logic [CW-1:0] FULL_AT = CW'(DEPTH - 2);
  localparam logic [W-1:0]  PC_ONE  = W'(1);

  logic [W-1:0]  ins_mem [DEPTH];
  logic [W-1:0]  pc_mem  [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] cnt;

  logic [AW-1:0] head_nx;
  logic [AW-1:0] tail_nx;
  logic [W-1:0]  head_ins;
  logic [W-1:0]  next_ins;
  logic          full_c;
  logic          do_enq;
  logic          do_iss;
  logic          do_dual;
  logic [CW-1:0] enq_n;
  logic [CW-1:0] iss_n;

  // jr, jal and beq redirect fetch, so they always issue alone.
  function automatic logic is_ctrl(input logic [W-1:0] ins);
    return (ins[31:26] == 6'b000000 && ins[5:0] == 6'b001000) ||
           (ins[31:26] == 6'b000011) || (ins[31:26] == 6'b000100);
  endfunction

  // Loads/stores go only to ALU1, which owns the memory port.
  function automatic logic is_mem(input logic [W-1:0] ins);
    return (ins[31:26] == 6'b100011) || (ins[31:26] == 6'b101011);
  endfunction

  // Register written by an instruction; 0 means no architectural write.
  function automatic logic [4:0] dest_of(input logic [W-1:0] ins);
    if (ins[31:26] == 6'b000000)
      return ins[15:11];
    else if (ins[31:26] == 6'b001000 || ins[31:26] == 6'b100011)
      return ins[20:16];
    else if (ins[31:26] == 6'b000011)
      return 5'd31;
    else
      return 5'd0;
  endfunction

  // The younger instruction may ride along only with no control flow,
  // no memory access and no RAW/WAW dependence on the older one.
  function automatic logic pair_ok(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [4:0] d;
    logic       raw;
    logic       waw;
    d   = dest_of(a);
    raw = (d != 5'd0) && (d == b[25:21] || d == b[20:16]);
    waw = (d != 5'd0) && (d == dest_of(b));
    return !is_ctrl(a) && !is_ctrl(b) && !is_mem(b) && !raw && !waw;
  endfunction

  assign head_nx  = head + PTR_ONE;
  assign tail_nx  = tail + PTR_ONE;
  assign head_ins = ins_mem[head];
  assign next_ins = ins_mem[head_nx];

  // Pairs are written two at a time, so fewer than two free slots is full.
  assign full_c  = cnt > FULL_AT;
  assign do_enq  = bus.in_valid && !bus.flush && !full_c;
  assign do_iss  = bus.issue_en && !bus.flush && (cnt != '0);
  assign do_dual = do_iss && (cnt >= CNT_TWO) && pair_ok(head_ins, next_ins);
  assign enq_n   = do_enq ? CNT_TWO : '0;
  assign iss_n   = do_dual ? CNT_TWO : (do_iss ? CNT_ONE : '0);

  assign bus.full  = full_c;
  assign bus.count = cnt;

  // Entry storage: payload only, contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (do_enq) begin
      ins_mem[tail]    <= bus.in_ins0;
      ins_mem[tail_nx] <= bus.in_ins1;
      pc_mem[tail]     <= bus.in_pc;
      pc_mem[tail_nx]  <= bus.in_pc + PC_ONE;
    end
  end

  // Pointer and occupancy bookkeeping; flush empties by snapping head to tail.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else if (bus.flush) begin
      head <= tail;
      cnt  <= '0;
    end else begin
      if (do_enq)
        tail <= tail + AW'(2);
      if (do_dual)
        head <= head + AW'(2);
      else if (do_iss)
        head <= head_nx;
      cnt <= cnt + enq_n - iss_n;
    end
  end

  // Registered issue outputs; idle cycles present NOPs while the PC holds.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.out_valid0 <= 1'b0;
      bus.out_dual   <= 1'b0;
      bus.out_ins0   <= '0;
      bus.out_ins1   <= '0;
      bus.out_pc0    <= '0;
    end else if (do_iss) begin
      bus.out_valid0 <= 1'b1;
      bus.out_dual   <= do_dual;
      bus.out_ins0   <= head_ins;
      bus.out_ins1   <= do_dual ? next_ins : '0;
      bus.out_pc0    <= pc_mem[head];
    end else begin
      bus.out_valid0 <= 1'b0;
      bus.out_dual   <= 1'b0;
      bus.out_ins0   <= '0;
      bus.out_ins1   <= '0;
    end
  end
endmodule

// File: tb/tb_issue_queue.sv
// Self-checking bench for issue_queue: directed scenarios plus a randomized
// run, all checked against a queue-based reference model.
module tb_issue_queue;
  localparam int DEPTH = 8;
  localparam int W     = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  issue_queue_if #(.DEPTH(DEPTH), .W(W)) bus ();

  issue_queue #(.DEPTH(DEPTH), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: program-order queue of {ins, pc} plus expected outputs.
  logic [31:0] q_ins[$];
  logic [31:0] q_pc[$];
  logic        e_v0;
  logic        e_dual;
  logic [31:0] e_i0;
  logic [31:0] e_i1;
  logic [31:0] e_pc0;

  function automatic logic [31:0] r_add(input int rs, input int rt, input int rd);
    return {6'b000000, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'b100000};
  endfunction

  function automatic int dst(input logic [31:0] x);
    int op;
    op = int'(x[31:26]);
    if (op == 0) return int'(x[15:11]);
    if (op == 8 || op == 35) return int'(x[20:16]);
    if (op == 3) return 31;
    return 0;
  endfunction

  function automatic bit ctl(input logic [31:0] x);
    return (x[31:26] == 6'd0 && x[5:0] == 6'd8) || x[31:26] == 6'd3 || x[31:26] == 6'd4;
  endfunction

  function automatic bit pair_ok(input logic [31:0] a, input logic [31:0] b);
    int d;
    d = dst(a);
    if (ctl(a) || ctl(b)) return 1'b0;
    if (b[31:26] == 6'd35 || b[31:26] == 6'd43) return 1'b0;
    if (d != 0 && (d == int'(b[25:21]) || d == int'(b[20:16]) || d == dst(b))) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] rand_ins();
    int a, b, c;
    a = $urandom_range(0, 7);
    b = $urandom_range(0, 7);
    c = $urandom_range(0, 7);
    case ($urandom_range(0, 9))
      0, 1, 2: return r_add(a, b, c);
      3:       return {6'b001000, 5'(a), 5'(b), 16'h0005};
      4:       return {6'b100011, 5'(a), 5'(b), 16'h0010};
      5:       return {6'b101011, 5'(a), 5'(b), 16'h0020};
      6:       return {6'b000011, 26'h0000040};
      7:       return {6'b000100, 5'(a), 5'(b), 16'h0002};
      8:       return {6'b000000, 5'(a), 15'd0, 6'b001000};
      default: return {6'b001101, 5'(a), 5'(b), 16'h00ff};
    endcase
  endfunction

  task automatic model_reset();
    q_ins.delete();
    q_pc.delete();
    e_v0 = 0; e_dual = 0; e_i0 = '0; e_i1 = '0; e_pc0 = '0;
  endtask

  task automatic drive(input bit v, input logic [31:0] i0, input logic [31:0] i1,
                       input logic [31:0] pc, input bit iss, input bit fl);
    bus.in_valid = v;
    bus.in_ins0  = i0;
    bus.in_ins1  = i1;
    bus.in_pc    = pc;
    bus.issue_en = iss;
    bus.flush    = fl;
  endtask

  // Advance one clock edge in both DUT and model; returns 1ns after the edge.
  task automatic tick();
    int sz;
    bit pre_full;
    sz       = q_ins.size();
    pre_full = (DEPTH - sz) < 2;
    @(posedge clk);
    if (bus.flush) begin
      q_ins.delete();
      q_pc.delete();
      e_v0 = 0; e_dual = 0; e_i0 = '0; e_i1 = '0;
    end else begin
      if (bus.issue_en && sz >= 1) begin
        e_v0   = 1;
        e_i0   = q_ins[0];
        e_pc0  = q_pc[0];
        e_dual = (sz >= 2) && pair_ok(q_ins[0], q_ins[1]);
        e_i1   = e_dual ? q_ins[1] : '0;
        void'(q_ins.pop_front());
        void'(q_pc.pop_front());
        if (e_dual) begin
          void'(q_ins.pop_front());
          void'(q_pc.pop_front());
        end
      end else begin
        e_v0 = 0; e_dual = 0; e_i0 = '0; e_i1 = '0;
      end
      if (bus.in_valid && !pre_full) begin
        q_ins.push_back(bus.in_ins0);
        q_ins.push_back(bus.in_ins1);
        q_pc.push_back(bus.in_pc);
        q_pc.push_back(bus.in_pc + 32'd1);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(0, '0, '0, '0, 0, 0);
    model_reset();
    #3;
    n_tests++;
    if (bus.count !== '0 || bus.full !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: count=%0d full=%b, required 0/0", bus.count, bus.full);
    end
    n_tests++;
    if ({bus.out_valid0, bus.out_dual, bus.out_ins0, bus.out_ins1, bus.out_pc0} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: v0=%b dual=%b i0=%h i1=%h pc=%h, required all 0",
               bus.out_valid0, bus.out_dual, bus.out_ins0, bus.out_ins1, bus.out_pc0);
    end
    #9 rst = 1'b1;
  endtask

  task automatic test_independent();
    logic [31:0] a, b;
    a = r_add(1, 2, 3);
    b = r_add(4, 5, 6);
    drive(1, a, b, 32'h10, 1, 0);
    tick();
    n_tests++;
    if (bus.count !== CW'(2) || bus.out_valid0 !== 1'b0) begin
      n_fail++;
      $display("FAIL indep_enq: count=%0d v0=%b, required 2/0", bus.count, bus.out_valid0);
    end
    drive(0, '0, '0, '0, 1, 0);
    tick();
    n_tests++;
    if (bus.out_valid0 !== 1'b1 || bus.out_dual !== 1'b1 || bus.out_pc0 !== 32'h10 ||
        bus.out_ins0 !== a || bus.out_ins1 !== b || bus.count !== '0) begin
      n_fail++;
      $display("FAIL indep_issue: v0=%b dual=%b pc=%h i0=%h i1=%h cnt=%0d, required 1/1/10/%h/%h/0",
               bus.out_valid0, bus.out_dual, bus.out_pc0, bus.out_ins0, bus.out_ins1, bus.count, a, b);
    end
  endtask

  task automatic test_raw();
    logic [31:0] a, b;
    a = {6'b001000, 5'd0, 5'd8, 16'd1};
    b = r_add(8, 8, 9);
    drive(1, a, b, 32'h40, 1, 0);
    tick();
    drive(0, '0, '0, '0, 1, 0);
    tick();
    n_tests++;
    if (bus.out_valid0 !== 1'b1 || bus.out_dual !== 1'b0 || bus.out_ins1 !== '0 ||
        bus.out_ins0 !== a || bus.out_pc0 !== 32'h40 || bus.count !== CW'(1)) begin
      n_fail++;
      $display("FAIL raw_first: v0=%b dual=%b i0=%h i1=%h pc=%h cnt=%0d, required 1/0/%h/0/40/1",
               bus.out_valid0, bus.out_dual, bus.out_ins0, bus.out_ins1, bus.out_pc0, bus.count, a);
    end
    tick();
    n_tests++;
    if (bus.out_valid0 !== 1'b1 || bus.out_dual !== 1'b0 || bus.out_ins0 !== b ||
        bus.out_pc0 !== 32'h41 || bus.count !== '0) begin
      n_fail++;
      $display("FAIL raw_second: v0=%b dual=%b i0=%h pc=%h cnt=%0d, required 1/0/%h/41/0",
               bus.out_valid0, bus.out_dual, bus.out_ins0, bus.out_pc0, bus.count, b);
    end
    tick();
    n_tests++;
    if (bus.out_valid0 !== 1'b0 || bus.out_ins0 !== '0 || bus.out_pc0 !== 32'h41) begin
      n_fail++;
      $display("FAIL idle_hold: v0=%b i0=%h pc=%h, required 0/0/41", bus.out_valid0, bus.out_ins0, bus.out_pc0);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      drive(1, r_add(1, 2, 10 + i), r_add(1, 2, 20 + i), 32'h100 + 32'(2 * i), 0, 0);
      tick();
    end
    n_tests++;
    if (bus.count !== CW'(8) || bus.full !== 1'b1) begin
      n_fail++;
      $display("FAIL fill_full: count=%0d full=%b, required 8/1", bus.count, bus.full);
    end
    drive(1, r_add(1, 2, 30), r_add(1, 2, 31), 32'h200, 0, 0);
    tick();
    n_tests++;
    if (bus.count !== CW'(8) || bus.full !== 1'b1 || q_ins.size() != 8) begin
      n_fail++;
      $display("FAIL fill_hold: count=%0d full=%b, required 8/1", bus.count, bus.full);
    end
    drive(0, '0, '0, '0, 1, 0);
    tick();
    n_tests++;
    if (bus.count !== CW'(6) || bus.full !== 1'b0 || bus.out_ins0 !== r_add(1, 2, 10)) begin
      n_fail++;
      $display("FAIL fill_drain: count=%0d full=%b i0=%h, required 6/0/%h",
               bus.count, bus.full, bus.out_ins0, r_add(1, 2, 10));
    end
    for (int k = 0; k < 6 && q_ins.size() != 0; k++) begin
      tick();
      n_tests++;
      if ({bus.out_valid0, bus.out_dual, bus.out_ins0, bus.out_ins1, bus.out_pc0, bus.count} !==
          {e_v0, e_dual, e_i0, e_i1, e_pc0, CW'(q_ins.size())}) begin
        n_fail++;
        $display("FAIL fill_model k%0d: v0=%b d=%b i0=%h i1=%h pc=%h cnt=%0d, required %b/%b/%h/%h/%h/%0d",
                 k, bus.out_valid0, bus.out_dual, bus.out_ins0, bus.out_ins1, bus.out_pc0, bus.count,
                 e_v0, e_dual, e_i0, e_i1, e_pc0, q_ins.size());
      end
    end
  endtask

  task automatic test_ctrl_mem();
    logic [31:0] add_a, lw_b, jal_a, add_b;
    add_a = r_add(1, 2, 3);
    lw_b  = {6'b100011, 5'd5, 5'd4, 16'h0000};
    jal_a = {6'b000011, 26'h0000040};
    add_b = r_add(6, 7, 12);
    drive(1, add_a, lw_b, 32'h300, 0, 0);
    tick();
    drive(0, '0, '0, '0, 1, 0);
    tick();
    n_tests++;
    if (bus.out_valid0 !== 1'b1 || bus.out_dual !== 1'b0 || bus.out_ins0 !== add_a || bus.out_ins1 !== '0) begin
      n_fail++;
      $display("FAIL mem_single: v0=%b dual=%b i0=%h i1=%h, required 1/0/%h/0",
               bus.out_valid0, bus.out_dual, bus.out_ins0, bus.out_ins1, add_a);
    end
    tick();
    drive(1, jal_a, add_b, 32'h400, 0, 0);
    tick();
    drive(1, r_add(1, 2, 13), r_add(1, 2, 14), 32'h402, 0, 0);
    tick();
    drive(1, r_add(1, 2, 15), r_add(1, 2, 16), 32'h404, 0, 0);
    tick();
    drive(0, '0, '0, '0, 1, 0);
    tick();
    n_tests++;
    if (bus.out_valid0 !== 1'b1 || bus.out_dual !== 1'b0 || bus.out_ins0 !== jal_a ||
        bus.out_pc0 !== 32'h400 || bus.count !== CW'(5)) begin
      n_fail++;
      $display("FAIL ctrl_single: v0=%b dual=%b i0=%h pc=%h cnt=%0d, required 1/0/%h/400/5",
               bus.out_valid0, bus.out_dual, bus.out_ins0, bus.out_pc0, bus.count, jal_a);
    end
    drive(1, r_add(1, 2, 17), r_add(1, 2, 18), 32'h500, 1, 1);
    tick();
    n_tests++;
    if (bus.count !== '0 || bus.out_valid0 !== 1'b0 || bus.out_dual !== 1'b0 ||
        bus.out_ins0 !== '0 || bus.out_ins1 !== '0) begin
      n_fail++;
      $display("FAIL flush: cnt=%0d v0=%b dual=%b i0=%h i1=%h, required 0/0/0/0/0",
               bus.count, bus.out_valid0, bus.out_dual, bus.out_ins0, bus.out_ins1);
    end
    drive(0, '0, '0, '0, 0, 0);
    tick();
  endtask

  task automatic test_wrap();
    logic [31:0] want_i[$], want_p[$], got_i[$], got_p[$];
    int bad;
    for (int i = 0; i < 20 + 6; i++) begin
      if (i < 20) begin
        logic [31:0] a, b;
        int d1;
        d1 = $urandom_range(8, 31);
        a  = r_add($urandom_range(0, 7), $urandom_range(0, 7), d1);
        b  = r_add($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(1, 7));
        want_i.push_back(a); want_i.push_back(b);
        want_p.push_back(32'h800 + 32'(2 * i)); want_p.push_back(32'h801 + 32'(2 * i));
        drive(1, a, b, 32'h800 + 32'(2 * i), 1, 0);
      end else begin
        drive(0, '0, '0, '0, 1, 0);
      end
      tick();
      if (bus.out_valid0 === 1'b1) begin
        got_i.push_back(bus.out_ins0);
        got_p.push_back(bus.out_pc0);
      end
      if (bus.out_dual === 1'b1) begin
        got_i.push_back(bus.out_ins1);
        got_p.push_back(bus.out_pc0 + 32'd1);
      end
    end
    n_tests++;
    if (got_i.size() != 40) begin
      n_fail++;
      $display("FAIL wrap_count: issued %0d instructions, required 40", got_i.size());
    end
    bad = -1;
    for (int k = 0; k < 40 && k < got_i.size(); k++)
      if (bad < 0 && (got_i[k] !== want_i[k] || got_p[k] !== want_p[k])) bad = k;
    n_tests++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL wrap_order: slot %0d got %h@%h, required %h@%h",
               bad, got_i[bad], got_p[bad], want_i[bad], want_p[bad]);
    end
  endtask

  task automatic test_async_reset();
    drive(1, r_add(1, 2, 10), r_add(1, 2, 11), 32'h900, 0, 0);
    tick();
    drive(1, r_add(1, 2, 12), r_add(1, 2, 13), 32'h902, 0, 0);
    tick();
    drive(1, r_add(1, 2, 14), r_add(1, 2, 15), 32'h904, 0, 0);
    tick();
    drive(1, r_add(1, 2, 16), r_add(1, 2, 17), 32'h906, 1, 0);
    tick();
    n_tests++;
    if (bus.count !== CW'(6) || bus.out_valid0 !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_setup: cnt=%0d v0=%b, required 6/1", bus.count, bus.out_valid0);
    end
    drive(0, '0, '0, '0, 0, 0);
    #2 rst = 1'b0;
    #1;
    n_tests++;
    if (bus.count !== '0 || bus.full !== 1'b0 ||
        {bus.out_valid0, bus.out_dual, bus.out_ins0, bus.out_ins1, bus.out_pc0} !== '0) begin
      n_fail++;
      $display("FAIL areset: cnt=%0d full=%b v0=%b dual=%b i0=%h i1=%h pc=%h, required all 0",
               bus.count, bus.full, bus.out_valid0, bus.out_dual, bus.out_ins0, bus.out_ins1, bus.out_pc0);
    end
    #1 rst = 1'b1;
    model_reset();
    drive(1, r_add(1, 2, 20), r_add(1, 2, 21), 32'ha00, 0, 0);
    tick();
    n_tests++;
    if (bus.count !== CW'(2)) begin
      n_fail++;
      $display("FAIL post_reset_enq: cnt=%0d, required 2", bus.count);
    end
  endtask

  task automatic test_random();
    logic [31:0] pc;
    pc = 32'h1000;
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 9) < 7, rand_ins(), rand_ins(), pc,
            $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
      tick();
      pc = pc + 32'd2;
      n_tests++;
      if ({bus.out_valid0, bus.out_dual, bus.out_ins0, bus.out_ins1, bus.out_pc0, bus.count, bus.full} !==
          {e_v0, e_dual, e_i0, e_i1, e_pc0, CW'(q_ins.size()), (DEPTH - q_ins.size()) < 2}) begin
        n_fail++;
        $display("FAIL random c%0d: v0=%b d=%b i0=%h i1=%h pc=%h cnt=%0d full=%b, required %b/%b/%h/%h/%h/%0d",
                 c, bus.out_valid0, bus.out_dual, bus.out_ins0, bus.out_ins1, bus.out_pc0, bus.count,
                 bus.full, e_v0, e_dual, e_i0, e_i1, e_pc0, q_ins.size());
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_independent();
    test_raw();
    test_fill();
    test_ctrl_mem();
    test_wrap();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
